// File: rtl/multicycle_sequencer.sv
// Multicycle instruction sequencer: fetch handshake, class decode, per-class micro-steps,
// memory wait states, sticky illegal-opcode trap and a wrapping retired-instruction counter.
module multicycle_sequencer #(
  parameter int DATA_W    = 32,
  parameter int STEP_W    = 3,
  parameter int STEPS_REG = 1,
  parameter int STEPS_IMM = 1,
  parameter int STEPS_BR  = 1,
  parameter int STEPS_LS  = 2,
  parameter int SIGN_EXT  = 1,
  parameter int CNT_W     = 16
) (
  input  logic              i_clock,
  input  logic              i_rst_n,
  input  logic [31:0]       i_ir,
  input  logic              i_ir_valid,
  input  logic [3:0]        i_status,
  input  logic              i_mem_ready,
  input  logic              i_stall,
  output logic              o_fetch_req,
  output logic              o_mem_req,
  output logic [2:0]        o_cls,
  output logic [STEP_W-1:0] o_step,
  output logic [DATA_W-1:0] o_k,
  output logic [3:0]        o_status_q,
  output logic              o_done,
  output logic              o_trap,
  output logic [CNT_W-1:0]  o_retired
);

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_TRAP} state_t;

  localparam logic [2:0] CLS_REG = 3'd0;
  localparam logic [2:0] CLS_IMM = 3'd1;
  localparam logic [2:0] CLS_BR  = 3'd2;
  localparam logic [2:0] CLS_LS  = 3'd3;
  localparam logic [2:0] CLS_ILL = 3'd7;

  localparam logic [STEP_W-1:0] LAST_REG = STEP_W'(STEPS_REG - 1);
  localparam logic [STEP_W-1:0] LAST_IMM = STEP_W'(STEPS_IMM - 1);
  localparam logic [STEP_W-1:0] LAST_BR  = STEP_W'(STEPS_BR - 1);
  localparam logic [STEP_W-1:0] LAST_LS  = STEP_W'(STEPS_LS - 1);
  localparam logic              SE       = (SIGN_EXT != 0);

  state_t             r_state, w_state_next;
  logic [STEP_W-1:0]  r_step, w_step_next;
  logic [31:0]        r_ir, w_ir_next;
  logic [2:0]         r_cls, w_cls_next;
  logic [3:0]         r_status, w_status_next;
  logic [CNT_W-1:0]   r_retired, w_retired_next;
  logic [STEP_W-1:0]  w_last;
  logic               w_mem_req;
  logic               w_adv;
  logic [2:0]         w_dec;
  logic [DATA_W-1:0]  w_k;
  logic               w_unused_ir;

  function automatic logic [2:0] f_decode(input logic [31:0] ir);
    if (ir[27] && ir[25] && !ir[26])       return CLS_REG;
    else if (ir[28] && !ir[27] && ir[26])  return CLS_BR;
    else if (ir[28] && !ir[27] && !ir[26]) return CLS_IMM;
    else if (ir[27] && !ir[25])            return CLS_LS;
    else                                   return CLS_ILL;
  endfunction

  // Class-selection bits of the latched word never feed the immediate.
  assign w_unused_ir = ^r_ir[28:26];

  assign w_dec     = f_decode(i_ir);
  assign w_mem_req = (r_state == S_EXEC) && (r_cls == CLS_LS) && (r_step == STEP_W'(1));
  assign w_adv     = !i_stall && !(w_mem_req && !i_mem_ready);

  always_comb begin
    w_last = '0;
    case (r_cls)
      CLS_REG: w_last = LAST_REG;
      CLS_IMM: w_last = LAST_IMM;
      CLS_BR:  w_last = LAST_BR;
      CLS_LS:  w_last = LAST_LS;
      default: w_last = '0;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_FETCH;
      r_step    <= '0;
      r_ir      <= '0;
      r_cls     <= CLS_REG;
      r_status  <= '0;
      r_retired <= '0;
    end else begin
      r_state   <= w_state_next;
      r_step    <= w_step_next;
      r_ir      <= w_ir_next;
      r_cls     <= w_cls_next;
      r_status  <= w_status_next;
      r_retired <= w_retired_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_step_next    = r_step;
    w_ir_next      = r_ir;
    w_cls_next     = r_cls;
    w_status_next  = r_status;
    w_retired_next = r_retired;
    o_fetch_req    = 1'b0;
    o_done         = 1'b0;
    o_trap         = 1'b0;
    case (r_state)
      S_FETCH: begin
        o_fetch_req = !i_stall;
        if (i_ir_valid && !i_stall) begin
          w_ir_next     = i_ir;
          w_status_next = i_status;
          w_step_next   = '0;
          w_cls_next    = w_dec;
          w_state_next  = (w_dec == CLS_ILL) ? S_TRAP : S_EXEC;
        end
      end
      S_EXEC: begin
        if (w_adv) begin
          if (r_step == w_last) begin
            o_done         = 1'b1;
            w_retired_next = r_retired + 1'b1;
            w_state_next   = S_FETCH;
          end else begin
            w_step_next = r_step + 1'b1;
          end
        end
      end
      S_TRAP:  o_trap = 1'b1;
      default: w_state_next = S_FETCH;
    endcase
  end

  // Immediate is only meaningful while executing; it reads as zero otherwise.
  always_comb begin
    w_k = '0;
    if (r_state == S_EXEC) begin
      case (r_cls)
        CLS_REG: w_k = DATA_W'(r_ir[15:10]);
        CLS_IMM: w_k = DATA_W'(r_ir[21:10]);
        CLS_LS:  w_k = {{(DATA_W-9){SE & r_ir[20]}}, r_ir[20:12]};
        CLS_BR: begin
          if (r_ir[31:29] == 3'b000)
            w_k = {{(DATA_W-26){SE & r_ir[25]}}, r_ir[25:0]};
          else
            w_k = {{(DATA_W-19){SE & r_ir[23]}}, r_ir[23:5]};
        end
        default: w_k = '0;
      endcase
    end
  end

  assign o_mem_req  = w_mem_req;
  assign o_cls      = r_cls;
  assign o_step     = r_step;
  assign o_k        = w_k;
  assign o_status_q = r_status;
  assign o_retired  = r_retired;

endmodule
